// File: rtl/dm_encode_sequencer_pkg.sv
// Shared types and constants for the data-memory encode sequencer.
//
// Contents:
//   seq_state_t : sequencer FSM states
//   MSG_BITS    : width of one raw message (11 data bits)
//   CODE_BITS   : width of one encoded SECDED word (16 bits)
package prog1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    FIN
  } seq_state_t;

  localparam int MSG_BITS  = 11;
  localparam int CODE_BITS = 16;

endpackage

// File: rtl/dm_encode_sequencer_if.sv
// Data-memory bus plus run status for the encode sequencer.
//
// Signals:
//   dm_rd_data : memory read data, combinational from dm_addr
//   dm_addr    : memory byte address
//   dm_wr_en   : write strobe, memory captures on posedge when high
//   dm_wr_data : write data
//   busy       : run in progress
//   done       : run finished, held until the next reset
//
// Modports:
//   master : the sequencer side
//   slave  : the memory / observer side
interface dm_encode_sequencer_if #(
  parameter int ADDR_W = 8
);

  logic [7:0]        dm_rd_data;
  logic [ADDR_W-1:0] dm_addr;
  logic              dm_wr_en;
  logic [7:0]        dm_wr_data;
  logic              busy;
  logic              done;

  modport master (
    input  dm_rd_data,
    output dm_addr, dm_wr_en, dm_wr_data, busy, done
  );

  modport slave (
    output dm_rd_data,
    input  dm_addr, dm_wr_en, dm_wr_data, busy, done
  );

endinterface

// File: rtl/dm_encode_sequencer_enc.sv
// Combinational Hamming(15,11) encoder with an overall parity bit (SECDED).
//
// Ports:
//   msg_i  [10:0] : message, msg_i[k-1] is data bit bk
//   code_o [15:0] : {b11..b5, p8, b4..b2, p4, b1, p2, p1, p0}
module hamming11_enc
  import prog1_pkg::*;
(
  input  logic [MSG_BITS-1:0]  msg_i,
  output logic [CODE_BITS-1:0] code_o
);

  logic p8, p4, p2, p1, p0;

  // Each check bit covers the data bits whose codeword position has that
  // power-of-two bit set; p0 then makes the whole 16-bit word even parity.
  always_comb begin
    p8 = ^msg_i[10:4];
    p4 = ^{msg_i[10:7], msg_i[3:1]};
    p2 = ^{msg_i[10], msg_i[9], msg_i[6], msg_i[5], msg_i[3], msg_i[2], msg_i[0]};
    p1 = ^{msg_i[10], msg_i[8], msg_i[6], msg_i[4], msg_i[3], msg_i[1], msg_i[0]};
    p0 = ^{msg_i, p8, p4, p2, p1};
    code_o = {msg_i[10:4], p8, msg_i[3:1], p4, msg_i[0], p2, p1, p0};
  end

endmodule

// File: rtl/dm_encode_sequencer.sv
// Sequencer for the program-1 SECDED encode pass over data memory.
// Reads NUM_MSG 11-bit messages (byte pairs at SRC_BASE), encodes each and
// writes the 16-bit result as a byte pair at DST_BASE, then raises done.
//
// Ports:
//   clk   : single clock, all state on posedge
//   reset : synchronous active-high; releasing it starts a run
//   bus   : data-memory port and busy/done status (master modport)
module dm_encode_sequencer
  import prog1_pkg::*;
#(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  dm_encode_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] SrcBase = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DstBase = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_MSG - 1);
  localparam longint AddrSpace = longint'(1) << ADDR_W;

  // Address arithmetic never wraps, so both buffers must fit and must not overlap.
  if (NUM_MSG < 1) begin : gNumMsgCheck
    $fatal(1, "NUM_MSG must be at least 1");
  end
  if (longint'(SRC_BASE) + 2 * NUM_MSG - 1 >= AddrSpace) begin : gSrcRangeCheck
    $fatal(1, "source buffer exceeds the address space");
  end
  if (longint'(DST_BASE) + 2 * NUM_MSG - 1 >= AddrSpace) begin : gDstRangeCheck
    $fatal(1, "destination buffer exceeds the address space");
  end
  if (!((SRC_BASE + 2 * NUM_MSG <= DST_BASE) ||
        (DST_BASE + 2 * NUM_MSG <= SRC_BASE))) begin : gOverlapCheck
    $fatal(1, "source and destination buffers overlap");
  end

  seq_state_t             state_q, state_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [7:0]             lo_q, lo_d;
  logic [2:0]             hi_q, hi_d;
  logic [CODE_BITS-1:0]   code;
  logic [ADDR_W-1:0]      msgOff;
  logic [ADDR_W-1:0]      dmAddr;
  logic                   wrEn;
  logic [7:0]             wrData;
  logic                   busyNow;

  hamming11_enc u_enc (
    .msg_i  ({hi_q, lo_q}),
    .code_o (code)
  );

  // State, message index and captured bytes; reset also aborts any run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  // Next state and memory-port drive; each message takes four cycles.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dmAddr  = '0;
    wrEn    = 1'b0;
    wrData  = '0;
    busyNow = 1'b0;
    msgOff  = idx_q << 1;

    case (state_q)
      IDLE: begin
        state_d = RD_LO;
      end
      RD_LO: begin
        busyNow = 1'b1;
        dmAddr  = SrcBase + msgOff;
        lo_d    = bus.dm_rd_data;
        state_d = RD_HI;
      end
      RD_HI: begin
        busyNow = 1'b1;
        dmAddr  = SrcBase + msgOff + ADDR_W'(1);
        hi_d    = bus.dm_rd_data[2:0];
        state_d = WR_LO;
      end
      WR_LO: begin
        busyNow = 1'b1;
        wrEn    = 1'b1;
        dmAddr  = DstBase + msgOff;
        wrData  = code[7:0];
        state_d = WR_HI;
      end
      WR_HI: begin
        busyNow = 1'b1;
        wrEn    = 1'b1;
        dmAddr  = DstBase + msgOff + ADDR_W'(1);
        wrData  = code[15:8];
        if (idx_q == LastIdx) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = RD_LO;
        end
      end
      FIN: begin
        state_d = FIN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset wins over a write that would land on the same edge.
  assign bus.dm_addr    = dmAddr;
  assign bus.dm_wr_en   = wrEn & ~reset;
  assign bus.dm_wr_data = wrData;
  assign bus.busy       = busyNow;
  assign bus.done       = (state_q == FIN);

endmodule

// File: tb/tb_dm_encode_sequencer.sv
`timescale 1ns/1ps
module tb_dm_encode_sequencer;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset1 = 1'b1;

  logic [7:0] mem  [256];
  logic [7:0] mem1 [256];

  int loVec [15];
  int hiVec [15];
  int expLo [15];
  int expHi [15];

  wr_t expQ[$];
  int  checks = 0;
  int  errors = 0;
  int  wr1Count = 0;

  dm_encode_sequencer_if #(.ADDR_W(8)) bus ();
  dm_encode_sequencer_if #(.ADDR_W(8)) bus1 ();

  dm_encode_sequencer #(
    .NUM_MSG(15), .SRC_BASE(0), .DST_BASE(30), .ADDR_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dm_encode_sequencer #(
    .NUM_MSG(1), .SRC_BASE(0), .DST_BASE(30), .ADDR_W(8)
  ) dutOne (
    .clk   (clk),
    .reset (reset1),
    .bus   (bus1)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Byte-wide memories with combinational read, as the sequencer expects.
  assign bus.dm_rd_data  = mem[bus.dm_addr];
  assign bus1.dm_rd_data = mem1[bus1.dm_addr];

  // Memory write ports: capture on posedge when the strobe is high.
  always @(posedge clk) begin
    if (bus.dm_wr_en) mem[bus.dm_addr] = bus.dm_wr_data;
    if (bus1.dm_wr_en) mem1[bus1.dm_addr] = bus1.dm_wr_data;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every write the DUT presents must match the next
  // queued expectation, and writes may only appear while the run is busy.
  always @(negedge clk) begin
    if (bus.dm_wr_en) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                 bus.dm_addr, bus.dm_wr_data);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("wr_addr", int'(bus.dm_addr), e.addr);
        checkOutput("wr_data", int'(bus.dm_wr_data), e.data);
        checkOutput("wr_while_busy", int'(bus.busy), 1);
      end
    end
    if (bus1.dm_wr_en) wr1Count++;
  end

  // Loads the source messages, clears the destination area and queues the
  // expected writes for messages [0, count).
  task automatic applyStimulus(input int count);
    for (int i = 0; i < 15; i++) begin
      mem[2*i]        = 8'(loVec[i]);
      mem[2*i+1]      = 8'(hiVec[i]);
      mem[30 + 2*i]   = 8'h00;
      mem[30 + 2*i+1] = 8'h00;
    end
    for (int i = 0; i < count; i++) begin
      expQ.push_back('{addr: 30 + 2*i,     data: expLo[i]});
      expQ.push_back('{addr: 30 + 2*i + 1, data: expHi[i]});
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_addr"},    int'(bus.dm_addr), 0);
    checkOutput({tag, "_wr_en"},   int'(bus.dm_wr_en), 0);
    checkOutput({tag, "_wr_data"}, int'(bus.dm_wr_data), 0);
    checkOutput({tag, "_busy"},    int'(bus.busy), 0);
    checkOutput({tag, "_done"},    int'(bus.done), 0);
  endtask

  // Releases reset just after a posedge and counts edges until done rises,
  // bounded so a stuck sequencer still reaches the summary.
  task automatic releaseAndWaitDone(input int expectCycles, input string tag);
    int n;
    n = 0;
    reset = 1'b0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        checkOutput({tag, "_start_addr"}, int'(bus.dm_addr), 0);
        checkOutput({tag, "_start_busy"}, int'(bus.busy), 1);
      end
      if (bus.done) break;
    end
    checkOutput({tag, "_done_latency"}, n, expectCycles);
    checkOutput({tag, "_busy_at_done"}, int'(bus.busy), 0);
    checkOutput({tag, "_queue_drained"}, expQ.size(), 0);
  endtask

  task automatic checkDestMemory(input string tag);
    for (int i = 0; i < 15; i++) begin
      checkOutput($sformatf("%s_dst_lo%0d", tag, i), int'(mem[30 + 2*i]), expLo[i]);
      checkOutput($sformatf("%s_dst_hi%0d", tag, i), int'(mem[30 + 2*i + 1]), expHi[i]);
    end
  endtask

  // Hard stop in case anything above fails to make progress.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main directed sequence.
  initial begin
    int n;
    for (int a = 0; a < 256; a++) begin
      mem[a]  = 8'h00;
      mem1[a] = 8'h00;
    end

    // Run 1: all-zero messages encode to all-zero words.
    for (int i = 0; i < 15; i++) begin
      loVec[i] = 0; hiVec[i] = 0; expLo[i] = 0; expHi[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    applyStimulus(15);
    releaseAndWaitDone(61, "zero");
    checkDestMemory("zero");
    repeat (5) @(posedge clk);
    #1;
    checkOutput("done_held", int'(bus.done), 1);
    checkOutput("no_wr_in_fin", int'(bus.dm_wr_en), 0);

    // Reset while finished: done must drop after one edge.
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkResetOutputs("fin_reset");

    // Run 2: hand-computed vectors, including junk upper bits and the last slot.
    loVec[0]  = 'h55; hiVec[0]  = 'h05; expLo[0]  = 'h5A; expHi[0]  = 'hAA;
    loVec[1]  = 'h01; hiVec[1]  = 'h00; expLo[1]  = 'h0F; expHi[1]  = 'h00;
    loVec[2]  = 'hFF; hiVec[2]  = 'h07; expLo[2]  = 'hFF; expHi[2]  = 'hFF;
    loVec[3]  = 'h00; hiVec[3]  = 'hF8; expLo[3]  = 'h00; expHi[3]  = 'h00;
    loVec[7]  = 'h55; hiVec[7]  = 'h05; expLo[7]  = 'h5A; expHi[7]  = 'hAA;
    loVec[13] = 'h00; hiVec[13] = 'h04; expLo[13] = 'h17; expHi[13] = 'h81;
    loVec[14] = 'h01; hiVec[14] = 'h00; expLo[14] = 'h0F; expHi[14] = 'h00;
    applyStimulus(15);
    @(posedge clk);
    #1;
    releaseAndWaitDone(61, "vec");
    checkDestMemory("vec");

    // Run 3: abort during message 7 WR_LO, then rerun from message 0.
    reset = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(7);
    reset = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    checkOutput("abort_pre_addr", int'(bus.dm_addr), 44);
    checkOutput("abort_pre_wr_en", int'(bus.dm_wr_en), 1);
    reset = 1'b1;
    #1;
    checkOutput("abort_wr_suppressed", int'(bus.dm_wr_en), 0);
    @(posedge clk);
    #1;
    checkResetOutputs("abort");
    checkOutput("abort_mem44", int'(mem[44]), 0);
    checkOutput("abort_queue_drained", expQ.size(), 0);
    for (int i = 0; i < 15; i++) begin
      expQ.push_back('{addr: 30 + 2*i,     data: expLo[i]});
      expQ.push_back('{addr: 30 + 2*i + 1, data: expHi[i]});
    end
    releaseAndWaitDone(61, "rerun");
    checkDestMemory("rerun");

    // Single-message instance: two writes, done after five edges, then held.
    mem1[0] = 8'h55;
    mem1[1] = 8'h05;
    @(posedge clk);
    #1;
    checkOutput("one_reset_done", int'(bus1.done), 0);
    reset1 = 1'b0;
    n = 0;
    while (n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (bus1.done) break;
    end
    checkOutput("one_done_latency", n, 5);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("one_done_held", int'(bus1.done), 1);
    checkOutput("one_write_count", wr1Count, 2);
    checkOutput("one_dst_lo", int'(mem1[30]), 'h5A);
    checkOutput("one_dst_hi", int'(mem1[31]), 'hAA);
    checkOutput("one_no_extra", int'(mem1[32]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
